// File: rtl/irq_source_ctrl_if.sv
// irq_source_ctrl_if: request/handshake bundle between the
// interrupt source controller and its surroundings.
interface irq_source_ctrl_if;
  logic [1:0] irq_raw;
  logic       int_taken;
  logic       eret;
  logic [1:0] interrupt;
  logic [1:0] pending;
  logic       busy;
  logic [7:0] drop_cnt;

  modport master (
    output irq_raw,
    output int_taken,
    output eret,
    input  interrupt,
    input  pending,
    input  busy,
    input  drop_cnt
  );

  modport slave (
    input  irq_raw,
    input  int_taken,
    input  eret,
    output interrupt,
    output pending,
    output busy,
    output drop_cnt
  );
endinterface

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: sync + debounce two raw request lines, latch
// edges as pending, issue one request at a time to the pipeline.
module irq_source_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  irq_source_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0][7:0] cnt;
  logic [1:0]      ev;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] int_q;
  logic [1:0] int_d;
  logic [1:0] clr;
  logic [1:0] pend_q;
  logic [1:0] pend_d;
  logic [1:0] drop_vec;
  logic [7:0] drop_q;
  logic [7:0] drop_d;
  logic [8:0] drop_sum;

  // two-flop synchronizer for the asynchronous raw lines
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.irq_raw;
      s2 <= s1;
    end
  end

  // per-line debounce counter, saturating at DEB_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!s2[i])
          cnt[i] <= 8'd0;
        else if (cnt[i] != DEB_MAX)
          cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  // one event per debounced high period
  always_comb begin
    ev = '0;
    for (int i = 0; i < 2; i++)
      ev[i] = s2[i] && (cnt[i] == DEB_LAST);
  end

  // service FSM: issue, wait for take, wait for eret
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          clr     = pend_q[1] ? 2'b10 : 2'b01;
          int_d   = clr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.int_taken) begin
          int_d   = 2'b00;
          state_d = SVC;
        end
      end
      SVC: begin
        int_d = 2'b00;
        if (bus.eret)
          state_d = IDLE;
      end
      default: begin
        int_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // pending latch (set beats clear) and saturating drop count
  always_comb begin
    pend_d   = (pend_q & ~clr) | ev;
    drop_vec = ev & pend_q & ~clr;
    drop_sum = {1'b0, drop_q}
             + 9'(drop_vec[0])
             + 9'(drop_vec[1]);
    drop_d   = (drop_sum > 9'd255) ? 8'hff
                                   : drop_sum[7:0];
  end

  // state, output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.interrupt = int_q;
  assign bus.pending   = pend_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the request controller.
module tb_irq_source_ctrl;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_source_ctrl_if bus ();

  irq_source_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: raw history as a delay line, run lengths of highs,
  // plus which line is being serviced and whether it was taken
  bit [1:0] m_s1, m_s2;
  int       m_len [2];
  bit [1:0] m_pend;
  int       m_drop;
  int       m_line;
  bit       m_taken;

  function automatic logic [1:0] m_irq();
    if (m_line < 0 || m_taken) return 2'b00;
    return (m_line == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic cycle(input logic [1:0] raw,
                       input logic tk, input logic er);
    bit [1:0] ev;
    bit [1:0] clr;
    bus.irq_raw   = raw;
    bus.int_taken = tk;
    bus.eret      = er;
    if (rst) begin
      m_s1 = 0; m_s2 = 0;
      m_len[0] = 0; m_len[1] = 0;
      m_pend = 0; m_drop = 0;
      m_line = -1; m_taken = 0;
    end else begin
      ev = 0; clr = 0;
      for (int i = 0; i < 2; i++) begin
        m_len[i] = m_s2[i] ? m_len[i] + 1 : 0;
        ev[i] = (m_len[i] == DEB);
      end
      if (m_line < 0) begin
        if (m_pend != 0) begin
          m_line = m_pend[1] ? 1 : 0;
          clr[m_line] = 1'b1;
          m_taken = 0;
        end
      end else if (!m_taken) begin
        if (tk) m_taken = 1;
      end else if (er) begin
        m_line = -1;
      end
      for (int i = 0; i < 2; i++)
        if (ev[i] && m_pend[i] && !clr[i])
          m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
      m_pend = (m_pend & ~clr) | ev;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle(2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    n_tests++;
    if (bus.interrupt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_int: got %b want 00", bus.interrupt);
    end
    n_tests++;
    if (bus.pending !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_pend: got %b want 00", bus.pending);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_tests++;
    if (bus.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt);
    end
  endtask

  task automatic test_glitch();
    repeat (3) cycle(2'b10, 1'b0, 1'b0);
    repeat (8) cycle(2'b00, 1'b0, 1'b0);
    n_tests++;
    if (bus.pending !== 2'b00 || bus.interrupt !== 2'b00 ||
        bus.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch: got pend=%b int=%b drop=%0d want 00 00 0",
               bus.pending, bus.interrupt, bus.drop_cnt);
    end
  endtask

  task automatic test_single();
    repeat (5) cycle(2'b01, 1'b0, 1'b0);
    n_tests++;
    if (bus.pending !== 2'b00) begin
      n_fail++;
      $display("FAIL single_e4_pend: got %b want 00", bus.pending);
    end
    cycle(2'b01, 1'b0, 1'b0);
    n_tests++;
    if (bus.pending !== 2'b01 || bus.interrupt !== 2'b00) begin
      n_fail++;
      $display("FAIL single_e5: got pend=%b int=%b want 01 00",
               bus.pending, bus.interrupt);
    end
    cycle(2'b01, 1'b0, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b01 || bus.busy !== 1'b1 ||
        bus.pending !== 2'b00) begin
      n_fail++;
      $display("FAIL single_e6: got int=%b busy=%b pend=%b want 01 1 00",
               bus.interrupt, bus.busy, bus.pending);
    end
  endtask

  task automatic test_handshake();
    cycle(2'b01, 1'b1, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b00 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_taken: got int=%b busy=%b want 00 1",
               bus.interrupt, bus.busy);
    end
    cycle(2'b01, 1'b1, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b00 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_taken2: got int=%b busy=%b want 00 1",
               bus.interrupt, bus.busy);
    end
    cycle(2'b00, 1'b0, 1'b1);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.interrupt !== 2'b00) begin
      n_fail++;
      $display("FAIL hs_eret: got busy=%b int=%b want 0 00",
               bus.busy, bus.interrupt);
    end
    repeat (4) cycle(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    repeat (7) cycle(2'b11, 1'b0, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b10 || bus.pending !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_first: got int=%b pend=%b want 10 01",
               bus.interrupt, bus.pending);
    end
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1);
    n_tests++;
    if (bus.interrupt !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: got int=%b busy=%b want 00 0",
               bus.interrupt, bus.busy);
    end
    cycle(2'b00, 1'b0, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b01 || bus.pending !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_second: got int=%b pend=%b want 01 00",
               bus.interrupt, bus.pending);
    end
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1);
    repeat (2) cycle(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    repeat (7) cycle(2'b01, 1'b0, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_issue: got int=%b want 01", bus.interrupt);
    end
    cycle(2'b00, 1'b1, 1'b0);
    repeat (3) begin
      repeat (5) cycle(2'b01, 1'b0, 1'b0);
      repeat (3) cycle(2'b00, 1'b0, 1'b0);
    end
    n_tests++;
    if (bus.pending !== 2'b01 || bus.drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL drop_three: got pend=%b drop=%0d want 01 2",
               bus.pending, bus.drop_cnt);
    end
    repeat (300) begin
      repeat (4) cycle(2'b01, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
    end
    repeat (4) cycle(2'b00, 1'b0, 1'b0);
    n_tests++;
    if (bus.drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_sat: got %0d want 255", bus.drop_cnt);
    end
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b0);
    n_tests++;
    if (bus.interrupt !== 2'b01 || bus.pending !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_reissue: got int=%b pend=%b want 01 00",
               bus.interrupt, bus.pending);
    end
  endtask

  task automatic test_reset_mid();
    repeat (7) cycle(2'b01, 1'b0, 1'b0);
    n_tests++;
    if (bus.pending !== 2'b01 || bus.interrupt !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_pre: got pend=%b int=%b want 01 01",
               bus.pending, bus.interrupt);
    end
    rst = 1'b1;
    cycle(2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    n_tests++;
    if (bus.interrupt !== 2'b00 || bus.pending !== 2'b00 ||
        bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rmid: got int=%b pend=%b busy=%b drop=%0d want 00 00 0 0",
               bus.interrupt, bus.pending, bus.busy, bus.drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] raw;
    logic tk, er;
    raw = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
      tk = ($urandom_range(0, 5) == 0);
      er = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle(raw, tk, er);
      rst = 1'b0;
      n_tests++;
      if (bus.interrupt !== m_irq() || bus.pending !== m_pend ||
          bus.busy !== (m_line >= 0) ||
          bus.drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL random c%0d: got int=%b pend=%b busy=%b drop=%0d want %b %b %b %0d",
                 c, bus.interrupt, bus.pending, bus.busy, bus.drop_cnt,
                 m_irq(), m_pend, (m_line >= 0), m_drop);
      end
    end
  endtask

  initial begin
    bus.irq_raw   = 2'b00;
    bus.int_taken = 1'b0;
    bus.eret      = 1'b0;
    m_line = -1;
    #1;
    test_reset();
    test_glitch();
    test_single();
    test_handshake();
    test_priority();
    test_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
